control_unit_fsm: RTL and testbench
===================================

// Module: control_unit_fsm
// PURPOSE
//  Sequencer that drives the ALU_Operation code consumed by the ALU, plus all register-load, bus-select and memory strobes.
//  Runs fetch -> decode -> execute per instruction on a 12-bit datapath (AC, R, PC, AR, IR).
//  Takes Zflag from the AC block for conditional jumps; memory accesses use a req/ack handshake.
// PARAMETERS
//  reg_width  12  datapath width; IR[reg_width-1:reg_width-4] = opcode, IR[reg_width-5:0] = address
//  op_width    4  opcode field width
// PORTS
//  clk            in   1  system clock, all state changes on posedge
//  reset          in   1  synchronous, active-high
//  opcode         in   4  IR opcode field (valid from the cycle after ir_load)
//  Zflag          in   1  AC==0 flag from AC block
//  mem_ack        in   1  memory done: read data on bus / write accepted, this cycle
//  ALU_Operation  out  3  000 IDLE,001 Pass,010 Add,011 Sub,100 Mul,101 Plus1,110 Zero
//  ac_load        out  1  AC <= ALU result at posedge
//  r_load         out  1  R <= bus
//  ir_load        out  1  IR <= bus (memory data)
//  pc_inc         out  1  PC <= PC+1
//  pc_load        out  1  PC <= IR address field
//  ar_load        out  1  AR <= source picked by ar_src
//  ar_src         out  1  0: PC, 1: IR address field
//  mem_rd         out  1  read request, held until mem_ack
//  mem_wr         out  1  write request (bus = AC), held until mem_ack
//  bus_sel        out  2  00 MEM, 01 AC, 10 R, 11 IR addr
//  halted         out  1  high while in HALT
//  illegal        out  1  one-cycle pulse when an undefined opcode is decoded
// BEHAVIOUR
//  States: FETCH_A, FETCH_M, DECODE, EXEC, MEM_A, MEM_X, HALT. State is registered; outputs decode state+opcode.
//  Only exception: ac_load/ir_load in FETCH_M/MEM_X also depend on mem_ack.
//  Reset: state=FETCH_A; every output 0; ALU_Operation=IDLE(000). Reset beats any other input.
//  If reset hits mid-handshake, mem_rd/mem_wr are 0 the next cycle and memory drops the access.
//  FETCH_A: ar_load=1, ar_src=0 -> FETCH_M (1 cycle).
//  FETCH_M: mem_rd=1, bus_sel=00. If mem_ack=0, stay. If mem_ack=1: ir_load=1, pc_inc=1 -> DECODE.
//  DECODE: 1 cycle.
//    0 NOP -> FETCH_A.
//    1 LDAC, 2 STAC -> MEM_A.
//    F HALT -> HALT.
//    Undefined (C,D,E): illegal=1, handled as NOP -> FETCH_A.
//    All other opcodes -> EXEC.
//  EXEC: 1 cycle, then -> FETCH_A.
//    3 ADD: ALU=Add, bus_sel=R, ac_load.
//    4 SUB: ALU=Sub, bus_sel=R, ac_load.
//    5 MUL: ALU=Mul, bus_sel=R, ac_load (product truncated to reg_width LSBs).
//    6 INAC: ALU=Plus1, ac_load (FFF wraps to 000).
//    7 CLAC: ALU=Zero, ac_load.
//    8 MOVR: r_load, bus_sel=AC.
//    9 MVAC: ALU=Pass, bus_sel=R, ac_load.
//    A JUMP: pc_load.
//    B JMPZ: pc_load iff Zflag=1 (sampled in EXEC).
//  MEM_A: ar_load=1, ar_src=1 -> MEM_X.
//  MEM_X, LDAC: mem_rd=1, bus_sel=00, ALU=Pass; on mem_ack: ac_load=1 -> FETCH_A.
//  MEM_X, STAC: mem_wr=1, bus_sel=01; on mem_ack -> FETCH_A.
//  mem_rd and mem_wr are never high together, and never high outside FETCH_M/MEM_X.
//  A zero-wait ack (mem_ack high in the first FETCH_M/MEM_X cycle) is accepted.
//  A stray mem_ack in any other state is ignored.
//  HALT: halted=1, all strobes 0, ALU=IDLE; leave only via reset.
//  ALU_Operation=IDLE whenever no AC write happens. pc_load and pc_inc are never high together.
//  Latency with zero-wait memory: ALU/jump instr 4 cycles; LDAC/STAC 5 cycles.
// TESTING
//  1. Reset held 2 cycles, then released -> all outputs 0, ALU=000; FETCH_A strobes (ar_load=1, ar_src=0) on the 1st cycle after release.
//  2. ADD with mem_ack on the 1st FETCH_M cycle -> ALU_Operation=010, bus_sel=10, ac_load=1 exactly in cycle 4; pc_inc once.
//  3. LDAC with mem_ack delayed 3 cycles in MEM_X -> mem_rd high 4 cycles, ac_load only on the ack cycle, ALU=001.
//  4. JMPZ with Zflag=0, then with Zflag=1 -> pc_load 0 then 1; pc_inc only in FETCH_M.
//  5. Opcode D -> illegal pulses 1 cycle in DECODE, no strobes, back to FETCH_A. Opcode F -> halted=1 stays set 20 cycles until reset.
//  6. Reset asserted mid-STAC while mem_wr=1 -> mem_wr=0 next cycle, state FETCH_A after release.

Source files
------------

// File: rtl/control_unit_fsm.sv
// Instruction sequencer for the 12-bit accumulator datapath: fetch, decode, execute,
// driving ALU operation, register loads, bus select and req/ack memory strobes.
module control_unit_fsm #(
    parameter int unsigned op_width = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [op_width-1:0] opcode,
    input  logic                Zflag,
    input  logic                mem_ack,
    output logic [2:0]          ALU_Operation,
    output logic                ac_load,
    output logic                r_load,
    output logic                ir_load,
    output logic                pc_inc,
    output logic                pc_load,
    output logic                ar_load,
    output logic                ar_src,
    output logic                mem_rd,
    output logic                mem_wr,
    output logic [1:0]          bus_sel,
    output logic                halted,
    output logic                illegal
);

    typedef enum logic [2:0] {
        FETCH_A = 3'd0,
        FETCH_M = 3'd1,
        DECODE  = 3'd2,
        EXEC    = 3'd3,
        MEM_A   = 3'd4,
        MEM_X   = 3'd5,
        HALT    = 3'd6
    } state_t;

    localparam logic [2:0] ALU_IDLE  = 3'b000;
    localparam logic [2:0] ALU_PASS  = 3'b001;
    localparam logic [2:0] ALU_ADD   = 3'b010;
    localparam logic [2:0] ALU_SUB   = 3'b011;
    localparam logic [2:0] ALU_MUL   = 3'b100;
    localparam logic [2:0] ALU_PLUS1 = 3'b101;
    localparam logic [2:0] ALU_ZERO  = 3'b110;

    localparam logic [1:0] BUS_MEM = 2'b00;
    localparam logic [1:0] BUS_AC  = 2'b01;
    localparam logic [1:0] BUS_R   = 2'b10;

    localparam logic [op_width-1:0] OP_NOP  = op_width'(4'h0);
    localparam logic [op_width-1:0] OP_LDAC = op_width'(4'h1);
    localparam logic [op_width-1:0] OP_STAC = op_width'(4'h2);
    localparam logic [op_width-1:0] OP_ADD  = op_width'(4'h3);
    localparam logic [op_width-1:0] OP_SUB  = op_width'(4'h4);
    localparam logic [op_width-1:0] OP_MUL  = op_width'(4'h5);
    localparam logic [op_width-1:0] OP_INAC = op_width'(4'h6);
    localparam logic [op_width-1:0] OP_CLAC = op_width'(4'h7);
    localparam logic [op_width-1:0] OP_MOVR = op_width'(4'h8);
    localparam logic [op_width-1:0] OP_MVAC = op_width'(4'h9);
    localparam logic [op_width-1:0] OP_JUMP = op_width'(4'hA);
    localparam logic [op_width-1:0] OP_JMPZ = op_width'(4'hB);
    localparam logic [op_width-1:0] OP_UD_C = op_width'(4'hC);
    localparam logic [op_width-1:0] OP_UD_D = op_width'(4'hD);
    localparam logic [op_width-1:0] OP_UD_E = op_width'(4'hE);
    localparam logic [op_width-1:0] OP_HALT = op_width'(4'hF);

    state_t state, state_n;

    always_ff @(posedge clk) begin
        if (reset) state <= FETCH_A;
        else       state <= state_n;
    end

    // Outputs are a decode of state+opcode; reset forces everything quiet.
    always_comb begin
        state_n       = state;
        ALU_Operation = ALU_IDLE;
        ac_load       = 1'b0;
        r_load        = 1'b0;
        ir_load       = 1'b0;
        pc_inc        = 1'b0;
        pc_load       = 1'b0;
        ar_load       = 1'b0;
        ar_src        = 1'b0;
        mem_rd        = 1'b0;
        mem_wr        = 1'b0;
        bus_sel       = BUS_MEM;
        halted        = 1'b0;
        illegal       = 1'b0;

        if (!reset) begin
            unique case (state)
                FETCH_A: begin
                    ar_load = 1'b1;
                    state_n = FETCH_M;
                end
                FETCH_M: begin
                    mem_rd  = 1'b1;
                    bus_sel = BUS_MEM;
                    if (mem_ack) begin
                        ir_load = 1'b1;
                        pc_inc  = 1'b1;
                        state_n = DECODE;
                    end
                end
                DECODE: begin
                    unique case (opcode)
                        OP_NOP:                    state_n = FETCH_A;
                        OP_LDAC, OP_STAC:          state_n = MEM_A;
                        OP_HALT:                   state_n = HALT;
                        OP_UD_C, OP_UD_D, OP_UD_E: begin
                            illegal = 1'b1;
                            state_n = FETCH_A;
                        end
                        default:                   state_n = EXEC;
                    endcase
                end
                EXEC: begin
                    state_n = FETCH_A;
                    case (opcode)
                        OP_ADD:  begin ALU_Operation = ALU_ADD;   bus_sel = BUS_R; ac_load = 1'b1; end
                        OP_SUB:  begin ALU_Operation = ALU_SUB;   bus_sel = BUS_R; ac_load = 1'b1; end
                        OP_MUL:  begin ALU_Operation = ALU_MUL;   bus_sel = BUS_R; ac_load = 1'b1; end
                        OP_INAC: begin ALU_Operation = ALU_PLUS1; ac_load = 1'b1; end
                        OP_CLAC: begin ALU_Operation = ALU_ZERO;  ac_load = 1'b1; end
                        OP_MOVR: begin r_load = 1'b1; bus_sel = BUS_AC; end
                        OP_MVAC: begin ALU_Operation = ALU_PASS;  bus_sel = BUS_R; ac_load = 1'b1; end
                        OP_JUMP: pc_load = 1'b1;
                        OP_JMPZ: pc_load = Zflag;
                        default: ;
                    endcase
                end
                MEM_A: begin
                    ar_load = 1'b1;
                    ar_src  = 1'b1;
                    state_n = MEM_X;
                end
                MEM_X: begin
                    // Only LDAC/STAC reach here, so anything other than LDAC is a store.
                    if (opcode == OP_LDAC) begin
                        mem_rd        = 1'b1;
                        bus_sel       = BUS_MEM;
                        ALU_Operation = ALU_PASS;
                        ac_load       = mem_ack;
                    end else begin
                        mem_wr  = 1'b1;
                        bus_sel = BUS_AC;
                    end
                    if (mem_ack) state_n = FETCH_A;
                end
                HALT: begin
                    halted = 1'b1;
                end
                default: state_n = FETCH_A;
            endcase
        end
    end

endmodule

// File: tb/tb_control_unit_fsm.sv
// Directed bench for control_unit_fsm: per-cycle expected output vectors are queued at
// drive time and compared against the packed DUT outputs half a cycle later.
module tb_control_unit_fsm;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] opcode;
    logic       Zflag;
    logic       mem_ack;
    logic [2:0] ALU_Operation;
    logic       ac_load, r_load, ir_load, pc_inc, pc_load, ar_load, ar_src;
    logic       mem_rd, mem_wr, halted, illegal;
    logic [1:0] bus_sel;

    control_unit_fsm dut (
        .clk(clk), .reset(reset), .opcode(opcode), .Zflag(Zflag), .mem_ack(mem_ack),
        .ALU_Operation(ALU_Operation), .ac_load(ac_load), .r_load(r_load),
        .ir_load(ir_load), .pc_inc(pc_inc), .pc_load(pc_load), .ar_load(ar_load),
        .ar_src(ar_src), .mem_rd(mem_rd), .mem_wr(mem_wr), .bus_sel(bus_sel),
        .halted(halted), .illegal(illegal)
    );

    always #5 clk = ~clk;

    // {alu[2:0], ac_load, r_load, ir_load, pc_inc, pc_load, ar_load, ar_src,
    //  mem_rd, mem_wr, bus_sel[1:0], halted, illegal}
    localparam logic [15:0] V_QUIET   = 16'h0000;
    localparam logic [15:0] V_FA      = 16'h0080;
    localparam logic [15:0] V_FM_WAIT = 16'h0020;
    localparam logic [15:0] V_FM_ACK  = 16'h0620;
    localparam logic [15:0] V_ILL     = 16'h0001;
    localparam logic [15:0] V_MEM_A   = 16'h00C0;
    localparam logic [15:0] V_LD_WAIT = 16'h2020;
    localparam logic [15:0] V_LD_ACK  = 16'h3020;
    localparam logic [15:0] V_ST      = 16'h0014;
    localparam logic [15:0] V_HALT    = 16'h0002;

    logic [15:0] observed;
    assign observed = {ALU_Operation, ac_load, r_load, ir_load, pc_inc, pc_load, ar_load,
                       ar_src, mem_rd, mem_wr, bus_sel, halted, illegal};

    logic [15:0] sb_q[$];
    int compared   = 0;
    int mismatched = 0;

    // One clock cycle: drive inputs just after posedge, queue expectation, check at negedge.
    task automatic cyc(input logic rst, input logic [3:0] op, input logic z,
                       input logic ack, input logic [15:0] expv, input string tag);
        logic [15:0] want;
        reset   = rst;
        opcode  = op;
        Zflag   = z;
        mem_ack = ack;
        sb_q.push_back(expv);
        @(negedge clk);
        want = sb_q.pop_front();
        compared++;
        assert (observed === want)
        else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, observed, want);
        end
        @(posedge clk);
        #1;
    endtask

    // Zero-wait fetch of one instruction, then decode expectation.
    task automatic fetch(input logic [3:0] op, input logic [15:0] dec_exp, input string tag);
        cyc(1'b0, 4'h0, 1'b0, 1'b0, V_FA, {tag, "_fa"});
        cyc(1'b0, 4'h0, 1'b0, 1'b1, V_FM_ACK, {tag, "_fm"});
        cyc(1'b0, op, 1'b0, 1'b0, dec_exp, {tag, "_dec"});
    endtask

    typedef struct {
        logic [3:0]  op;
        logic        z;
        logic [15:0] ex;
        string       tag;
    } exec_t;

    exec_t exec_tbl[$];

    initial begin
        reset = 1'b1; opcode = 4'h0; Zflag = 1'b0; mem_ack = 1'b0;
        exec_tbl = '{
            '{4'h3, 1'b0, 16'h5008, "add"},
            '{4'h4, 1'b0, 16'h7008, "sub"},
            '{4'h5, 1'b0, 16'h9008, "mul"},
            '{4'h6, 1'b0, 16'hB000, "inac"},
            '{4'h7, 1'b0, 16'hD000, "clac"},
            '{4'h8, 1'b0, 16'h0804, "movr"},
            '{4'h9, 1'b1, 16'h3008, "mvac"},
            '{4'hA, 1'b0, 16'h0100, "jump"},
            '{4'hB, 1'b0, 16'h0000, "jmpz_z0"},
            '{4'hB, 1'b1, 16'h0100, "jmpz_z1"}
        };
        @(posedge clk);
        #1;

        // Reset held two cycles with noisy inputs, then FETCH_A strobes.
        cyc(1'b1, 4'h3, 1'b1, 1'b1, V_QUIET, "rst_c0");
        cyc(1'b1, 4'hF, 1'b0, 1'b0, V_QUIET, "rst_c1");

        // Every ALU/jump instruction: exec result in cycle 4, pc_inc only in FETCH_M.
        foreach (exec_tbl[i]) begin
            fetch(exec_tbl[i].op, V_QUIET, exec_tbl[i].tag);
            cyc(1'b0, exec_tbl[i].op, exec_tbl[i].z, 1'b0, exec_tbl[i].ex,
                {exec_tbl[i].tag, "_ex"});
        end

        // Fetch with wait states, then NOP with a stray ack in DECODE.
        cyc(1'b0, 4'h0, 1'b0, 1'b0, V_FA, "nop_fa");
        cyc(1'b0, 4'h0, 1'b0, 1'b0, V_FM_WAIT, "nop_fm_w0");
        cyc(1'b0, 4'h0, 1'b0, 1'b0, V_FM_WAIT, "nop_fm_w1");
        cyc(1'b0, 4'h0, 1'b0, 1'b1, V_FM_ACK, "nop_fm_ack");
        cyc(1'b0, 4'h0, 1'b0, 1'b1, V_QUIET, "nop_dec");

        // LDAC with ack delayed three cycles in MEM_X.
        fetch(4'h1, V_QUIET, "ldac");
        cyc(1'b0, 4'h1, 1'b0, 1'b1, V_MEM_A, "ldac_mema");
        for (int k = 0; k < 3; k++) cyc(1'b0, 4'h1, 1'b0, 1'b0, V_LD_WAIT, "ldac_wait");
        cyc(1'b0, 4'h1, 1'b0, 1'b1, V_LD_ACK, "ldac_ack");

        // STAC with one wait cycle.
        fetch(4'h2, V_QUIET, "stac");
        cyc(1'b0, 4'h2, 1'b0, 1'b0, V_MEM_A, "stac_mema");
        cyc(1'b0, 4'h2, 1'b0, 1'b0, V_ST, "stac_wait");
        cyc(1'b0, 4'h2, 1'b0, 1'b1, V_ST, "stac_ack");

        // Undefined opcodes pulse illegal once and return to fetch.
        fetch(4'hD, V_ILL, "ud_d");
        fetch(4'hC, V_ILL, "ud_c");
        fetch(4'hE, V_ILL, "ud_e");

        // Reset in the middle of a store drops mem_wr immediately.
        fetch(4'h2, V_QUIET, "strst");
        cyc(1'b0, 4'h2, 1'b0, 1'b0, V_MEM_A, "strst_mema");
        cyc(1'b0, 4'h2, 1'b0, 1'b0, V_ST, "strst_wr");
        cyc(1'b1, 4'h2, 1'b0, 1'b0, V_QUIET, "strst_rst");

        // HALT persists through stray acks until reset.
        fetch(4'hF, V_QUIET, "halt");
        for (int k = 0; k < 20; k++)
            cyc(1'b0, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), V_HALT, "halt_hold");
        cyc(1'b1, 4'h0, 1'b0, 1'b0, V_QUIET, "halt_rst");
        cyc(1'b0, 4'h0, 1'b0, 1'b0, V_FA, "post_halt_fa");
        cyc(1'b0, 4'h0, 1'b0, 1'b1, V_FM_ACK, "post_halt_fm");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
